// File: rtl/maze_pkg.sv
// Shared definitions for the maze path replayer: buffer geometry, move codes,
// endpoint locations, controller state encoding and the single-step helper.
package maze_pkg;

  localparam int unsigned DEPTH = 256;     // maximum number of buffered moves
  localparam int unsigned AW    = 8;       // buffer address width
  localparam int unsigned CW    = AW + 1;  // move counter width (counts 0..DEPTH)
  localparam int unsigned LW    = 8;       // location width {row, col}

  localparam logic [LW-1:0] START_LOC = 8'h00;
  localparam logic [LW-1:0] DEST_LOC  = 8'hFF;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_EMIT0   = 3'd2,
    ST_EMIT    = 3'd3,
    ST_FIN     = 3'd4
  } state_t;

  // One move from loc; returns {off_grid, next_loc}. next_loc equals loc when
  // the move would leave the 16x16 grid, so no wrapped nibble can escape.
  function automatic logic [LW:0] loc_step(input logic [LW-1:0] loc, input dir_t dir);
    logic [3:0] row;
    logic [3:0] col;
    logic       off;
    row = loc[7:4];
    col = loc[3:0];
    off = 1'b0;
    case (dir)
      DIR_UP:    if (row == 4'd0)  off = 1'b1; else row = row - 4'd1;
      DIR_RIGHT: if (col == 4'd15) off = 1'b1; else col = col + 4'd1;
      DIR_LEFT:  if (col == 4'd0)  off = 1'b1; else col = col - 4'd1;
      DIR_DOWN:  if (row == 4'd15) off = 1'b1; else row = row + 4'd1;
      default:   off = 1'b1;
    endcase
    return {off, row, col};
  endfunction

endpackage

// File: rtl/path_buffer.sv
// DEPTH x 2 register-file holding captured move codes.
// Ports: i_clk, i_we/i_waddr/i_wdata synchronous write; i_raddr -> o_rdata
// asynchronous read. Contents are not reset.
module path_buffer
  import maze_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [1:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [1:0]    o_rdata
);

  logic [1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/maze_path_replayer.sv
// Buffers the solver's popped move stream (reverse order) and replays it
// forward from START_LOC, emitting each visited cell over valid/ready and
// flagging whether the walk ends at DEST_LOC.
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_start                       begin capture (IDLE only)
//   i_dir_vld, i_dir_in, i_last   popped move stream
//   o_loc_out, o_out_vld, i_out_rdy   replayed locations
//   o_busy, o_done (pulse), o_err (sticky, valid with done)
module maze_path_replayer
  import maze_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_dir_vld,
  input  logic [1:0]    i_dir_in,
  input  logic          i_last,
  output logic [LW-1:0] o_loc_out,
  output logic          o_out_vld,
  input  logic          i_out_rdy,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  state_t        r_state;
  logic [CW-1:0] r_cnt;    // moves captured; low bits double as write pointer
  logic [AW-1:0] r_rptr;   // buffer index of the move shown on o_loc_out

  logic          w_full;
  logic          w_we;
  logic [CW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_raddr;
  logic [1:0]    w_rdata;
  logic          w_off;
  logic [LW-1:0] w_next;
  logic          w_end_err;

  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_we      = (r_state == ST_COLLECT) && i_dir_vld && !w_full;
  assign w_cnt_nxt = w_we ? r_cnt + CW'(1) : r_cnt;

  // EMIT0 fetches the newest entry; in EMIT the displayed entry is r_rptr, so
  // the look-ahead reads one below it.
  assign w_raddr = (r_state == ST_EMIT) ? r_rptr - AW'(1) : r_rptr;

  // o_loc_out always holds the current walk position, so it is the step origin
  assign {w_off, w_next} = loc_step(o_loc_out, dir_t'(w_rdata));

  // Path is wrong if the location being accepted is not the destination
  assign w_end_err = o_err || (o_loc_out != DEST_LOC);

  path_buffer u_buf (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_cnt[AW-1:0]),
    .i_wdata (i_dir_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Controller with registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rptr    <= '0;
      o_loc_out <= START_LOC;
      o_out_vld <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= ST_COLLECT;
            r_cnt     <= '0;
            r_rptr    <= '0;
            o_err     <= 1'b0;
            o_loc_out <= START_LOC;
            o_busy    <= 1'b1;
          end
        end

        ST_COLLECT: begin
          r_cnt <= w_cnt_nxt;
          if (i_dir_vld && w_full) o_err <= 1'b1;
          if (i_last) begin
            // a move arriving with last is already counted in w_cnt_nxt
            r_rptr    <= AW'(w_cnt_nxt - CW'(1));
            r_state   <= ST_EMIT0;
            o_loc_out <= START_LOC;
            o_out_vld <= 1'b1;
          end
        end

        ST_EMIT0: begin
          if (i_out_rdy) begin
            if (r_cnt == '0) begin
              r_state   <= ST_FIN;
              o_out_vld <= 1'b0;
              o_done    <= 1'b1;
              o_err     <= w_end_err;
            end else if (w_off) begin
              r_state   <= ST_FIN;
              o_out_vld <= 1'b0;
              o_done    <= 1'b1;
              o_err     <= 1'b1;
            end else begin
              r_state   <= ST_EMIT;
              o_loc_out <= w_next;
            end
          end
        end

        ST_EMIT: begin
          if (i_out_rdy) begin
            if (r_rptr == '0) begin
              r_state   <= ST_FIN;
              o_out_vld <= 1'b0;
              o_done    <= 1'b1;
              o_err     <= w_end_err;
            end else if (w_off) begin
              r_state   <= ST_FIN;
              o_out_vld <= 1'b0;
              o_done    <= 1'b1;
              o_err     <= 1'b1;
            end else begin
              o_loc_out <= w_next;
              r_rptr    <= r_rptr - AW'(1);
            end
          end
        end

        ST_FIN: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end

        default: begin
          r_state   <= ST_IDLE;
          o_out_vld <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_replayer.sv
// Self-checking bench for maze_path_replayer: a move-list walk model builds the
// expected beat sequence and error flag; a negedge monitor checks every beat.
module tb_maze_path_replayer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dir_vld = 1'b0;
  logic [1:0] dir_in = 2'b00;
  logic       last = 1'b0;
  logic       out_rdy = 1'b1;
  logic [7:0] loc_out;
  logic       out_vld;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_err;
  int         beat;
  int         done_seen;
  bit         mon_en = 1'b0;
  bit         rdy_toggle = 1'b0;

  always #5 clk = ~clk;

  maze_path_replayer dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_start   (start),
    .i_dir_vld (dir_vld),
    .i_dir_in  (dir_in),
    .i_last    (last),
    .o_loc_out (loc_out),
    .o_out_vld (out_vld),
    .i_out_rdy (out_rdy),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Walk the captured moves forward on a 16x16 grid from (0,0)
  task automatic build_model(input logic [1:0] codes[$]);
    int n, r, c, nr, nc;
    bit bad;
    n       = (codes.size() > 256) ? 256 : codes.size();
    exp_err = (codes.size() > 256);
    exp_q.delete();
    r = 0; c = 0; bad = 1'b0;
    exp_q.push_back(8'h00);
    for (int k = n - 1; k >= 0; k--) begin
      nr = r; nc = c;
      case (codes[k])
        2'b00:   nr = nr - 1;
        2'b01:   nc = nc + 1;
        2'b10:   nc = nc - 1;
        default: nr = nr + 1;
      endcase
      if (nr < 0 || nr > 15 || nc < 0 || nc > 15) begin
        bad = 1'b1;
        break;
      end
      r = nr; c = nc;
      exp_q.push_back(8'(r * 16 + c));
    end
    if (bad || r != 15 || c != 15) exp_err = 1'b1;
  endtask

  // Backpressure driver
  always @(posedge clk) begin
    #1;
    out_rdy = rdy_toggle ? ~out_rdy : 1'b1;
  end

  // Per-beat compare against the model
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_vld) begin
        if (beat < exp_q.size()) check("loc_beat", loc_out, exp_q[beat]);
        else check("extra_beat", beat, exp_q.size());
        if (out_rdy) beat++;
      end
      if (done) begin
        done_seen++;
        check("err_at_done", err, exp_err);
        check("beat_count", beat, exp_q.size());
      end
    end
  end

  task automatic push_path(input logic [1:0] codes[$]);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    for (int k = 0; k < codes.size(); k++) begin
      dir_vld = 1'b1;
      dir_in  = codes[k];
      last    = (k == codes.size() - 1);
      @(posedge clk); #1;
    end
    if (codes.size() == 0) begin
      last = 1'b1;
      @(posedge clk); #1;
    end
    dir_vld = 1'b0;
    last    = 1'b0;
    check("vld_after_last", out_vld, 1'b1);
    check("loc_emit0", loc_out, 8'h00);
  endtask

  task automatic run_case(input logic [1:0] codes[$], input bit toggle);
    bit got_done;
    build_model(codes);
    beat       = 0;
    done_seen  = 0;
    rdy_toggle = toggle;
    mon_en     = 1'b1;
    push_path(codes);
    got_done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check("done_seen", got_done, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("done_pulses", done_seen, 1);
    mon_en     = 1'b0;
    rdy_toggle = 1'b0;
  endtask

  logic [1:0] happy[$];
  logic [1:0] empty_p[$];
  logic [1:0] up_off[$];
  logic [1:0] right_off[$];
  logic [1:0] ovf[$];
  int         hs;
  bit         any_done;

  initial begin
    for (int i = 0; i < 15; i++) happy.push_back(2'b11);
    for (int i = 0; i < 15; i++) happy.push_back(2'b01);
    up_off.push_back(2'b00);
    for (int i = 0; i < 16; i++) right_off.push_back(2'b01);
    for (int i = 0; i < 257; i++) ovf.push_back((i % 2 == 1) ? 2'b01 : 2'b10);

    // Hand-computed anchors for the model
    build_model(happy);
    check("model_happy_len", exp_q.size(), 31);
    check("model_happy_1", exp_q[1], 8'h01);
    check("model_happy_15", exp_q[15], 8'h0F);
    check("model_happy_16", exp_q[16], 8'h1F);
    check("model_happy_30", exp_q[30], 8'hFF);
    check("model_happy_err", exp_err, 1'b0);
    build_model(up_off);
    check("model_off_len", exp_q.size(), 1);
    check("model_off_err", exp_err, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_loc", loc_out, 8'h00);
    check("rst_vld", out_vld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_case(happy, 1'b0);
    run_case(empty_p, 1'b0);
    run_case(happy, 1'b1);
    run_case(up_off, 1'b0);
    run_case(right_off, 1'b1);
    run_case(ovf, 1'b0);

    // Reset during the 10th beat
    push_path(happy);
    hs = 0;
    for (int cyc = 0; cyc < 200 && hs < 10; cyc++) begin
      @(negedge clk);
      if (out_vld && out_rdy) hs++;
    end
    check("mid_beat10_loc", loc_out, 8'h09);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_vld", out_vld, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_loc", loc_out, 8'h00);
    rst_n = 1'b1;
    any_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    check("no_done_after_rst", any_done, 1'b0);
    run_case(happy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/maze_path_replayer.md
# maze_path_replayer

Consumes the direction codes that the maze solver pops off its move stack after reaching the destination. The stack pops in reverse order, so the block buffers the whole stream, then replays it forward from the start cell 0x00. For each step it emits the visited cell location over a valid/ready handshake and finally reports whether the path ends at the destination 0xFF. It sits between the solver's stack pop output and the path display/checker logic.

## Interface
- DEPTH, 256, maximum number of buffered moves
- AW, 8, buffer address width (log2 DEPTH)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a new capture; honoured only in IDLE
- dir_vld  in  1  dir_in valid this cycle (one pop)
- dir_in  in  2  move code: 00 up (row-1), 01 right (col+1), 10 left (col-1), 11 down (row+1)
- last  in  1  stream end (solver stack empty); may coincide with dir_vld
- loc_out  out  8  location {row[3:0], col[3:0]}
- out_vld  out  1  loc_out valid
- out_rdy  in  1  consumer accepts loc_out
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of replay
- err  out  1  sticky error; valid when done is high, cleared by start

## Operation
- States:
  - IDLE: start moves to COLLECT and clears wptr, err and loc.
  - COLLECT: each dir_vld writes mem[wptr] and increments wptr; cnt is 9 bits wide.
  - EMIT0: presents 0x00.
  - EMIT: replays buffered moves.
  - FIN: pulses done, then returns to IDLE.
- COLLECT overflow: dir_vld with cnt==DEPTH drops the code and sets err. Capture continues until last.
- last in COLLECT:
  - If dir_vld is also high, the entry is stored first.
  - Then rptr = cnt-1 and the state moves to EMIT0.
- EMIT0: out_vld=1, loc_out=0x00. On out_rdy:
  - cnt==0 → FIN.
  - Otherwise → EMIT.
- EMIT: the next location is computed from loc and mem[rptr] (asynchronous read) and registered into loc_out.
  - out_vld is held until out_rdy.
  - On acceptance, rptr decrements.
  - After the entry at rptr==0 is accepted → FIN.
- Off-grid move (row 0 & up, row 15 & down, col 0 & left, col 15 & right):
  - The location is not emitted and err is set.
  - The state goes to FIN immediately.
  - No nibble wrap-around is ever output.
- FIN: done=1 for one cycle. err is additionally set if the last accepted loc != 0xFF.
- start outside IDLE is ignored. dir_vld and last outside COLLECT are ignored.
- out_rdy without out_vld has no effect.

## Timing
- Reset (rst=0 at a clock edge): state IDLE, loc_out=0x00, out_vld=0, busy=0, done=0, err=0, wptr=rptr=0. Applying reset mid-capture or mid-replay aborts with no done pulse. Buffer contents are don't-care.
- start → busy high the next cycle.
- last → out_vld high the next cycle (EMIT0).
- EMIT throughput: one location per cycle while out_rdy is held high. Each new loc_out appears the cycle after the previous one is accepted.
- loc_out and out_vld are stable while out_vld=1 and out_rdy=0.
- done is asserted the cycle after the final handshake or the error, then IDLE follows. A new start is accepted the cycle after done.

## Structure
- Shared package (maze_pkg):
  - Direction codes DIR_UP, DIR_RIGHT, DIR_LEFT, DIR_DOWN.
  - START_LOC=8'h00 and DEST_LOC=8'hFF.
  - The state encoding.
  - A loc_step function returning {off_grid, next_loc}.
- One sub-module is natural: path_buffer, a DEPTH×2 register-file RAM with synchronous write and asynchronous read.

## Test plan
- Happy path:
  - Stimulus: start; push 15×11 then 15×01, with last on the final push; out_rdy=1.
  - Response: loc_out 0x00, 0x01 … 0x0F, 0x1F, 0x2F … 0xFF (31 beats); done pulse; err=0.
- Empty path: start, then last with no dir_vld → single beat 0x00; done; err=1.
- Backpressure:
  - Stimulus: happy path with out_rdy toggling 1010….
  - Response: same 31 values with none skipped or duplicated, and loc_out stable while stalled.
- Off-grid:
  - Stimulus: push a single 00 (up) with last.
  - Response: beat 0x00 only; done; err=1; no wrapped 0xF0 output.
- Overflow: push 257 codes → err=1 at done, and only 256 are replayed (or the replay stops earlier on an off-grid move).
- Reset mid-replay: rst=0 during the 10th beat → next cycle out_vld=0, busy=0, no done; a subsequent start runs cleanly.
